// File: rtl/spi_slave_pkg.sv
// Shared types and constants for the SPI responder-side transfer engine.
package spi_slave_pkg;

  typedef enum logic [1:0] {
    WAIT_SS_HIGH,
    IDLE,
    SHIFT,
    DONE
  } state_t;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

  localparam int unsigned SYNC_STAGES = 2;

  // Ones in bits [len:0], zeros above.
  function automatic logic [31:0] len_mask(input logic [4:0] len);
    return 32'hFFFF_FFFF >> (5'd31 - len);
  endfunction

endpackage

// File: rtl/spi_input_synchronizer.sv
// Multi-stage synchronizer for an asynchronous pin plus registered-level edge detection.
module spi_input_synchronizer
  import spi_slave_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic async_in,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] stages;
  logic                   prev;

  // Stages reset low so a pin already held high is seen as a fresh rising level.
  always_ff @(posedge clock) begin
    if (!reset) begin
      stages <= '0;
      prev   <= 1'b0;
    end else begin
      stages <= {stages[SYNC_STAGES-2:0], async_in};
      prev   <= stages[SYNC_STAGES-1];
    end
  end

  assign sync = stages[SYNC_STAGES-1];
  assign rise = sync & ~prev;
  assign fall = ~sync & prev;

endmodule

// File: rtl/spi_slave_transfer_engine.sv
// SPI responder transfer engine: multi-lane MSB-first shift in/out, word-masked rx bus.
module spi_slave_transfer_engine
  import spi_slave_pkg::*;
#(
  parameter int unsigned N_CHANNELS   = 3,
  parameter int unsigned OUTPUT_WIDTH = 32
) (
  input  logic                                      clock,
  input  logic                                      reset,
  input  logic                                      spi_sclk,
  input  logic                                      spi_ss_n,
  input  logic [N_CHANNELS-1:0]                     spi_mosi,
  output logic [N_CHANNELS-1:0]                     spi_miso,
  input  logic                                      clock_polarity,
  input  logic                                      clock_phase,
  input  logic [4:0]                                transfer_length,
  input  logic [N_CHANNELS-1:0][OUTPUT_WIDTH-1:0]   tx_data,
  input  logic                                      tx_data_valid,
  output logic                                      tx_ready,
  output logic [N_CHANNELS-1:0][OUTPUT_WIDTH-1:0]   rx_data,
  output logic                                      rx_valid,
  output logic                                      transfer_aborted,
  output logic                                      tx_underrun
);

  localparam logic [4:0] MAX_LEN = 5'(OUTPUT_WIDTH - 1);

  state_t    state, state_next;
  spi_mode_t mode_q;
  logic [4:0] len_q, len_in;
  logic [5:0] bit_cnt;
  logic       drive, tx_have;
  logic [N_CHANNELS-1:0][OUTPUT_WIDTH-1:0] tx_hold, tx_shift, rx_next, rx_masked;
  logic [N_CHANNELS-1:0][OUTPUT_WIDTH-2:0] rx_shift;
  logic [SYNC_STAGES-1:0][N_CHANNELS-1:0]  mosi_pipe;
  logic [N_CHANNELS-1:0] mosi_sync;
  logic [31:0] mask;
  logic sclk_sync, sclk_rise, sclk_fall, ss_sync, ss_rise, ss_fall;
  logic sclk_edge, lead_edge, trail_edge, sample_edge, shift_edge;
  logic frame_start, sample_now, shift_now, finish_now, abort_now, tx_capture;

  spi_input_synchronizer u_sclk_sync (
    .clock(clock), .reset(reset), .async_in(spi_sclk),
    .sync(sclk_sync), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_input_synchronizer u_ss_sync (
    .clock(clock), .reset(reset), .async_in(spi_ss_n),
    .sync(ss_sync), .rise(ss_rise), .fall(ss_fall)
  );

  // Same depth as the sclk path, so mosi_sync is the lane value at the detected edge.
  always_ff @(posedge clock) begin
    if (!reset) begin
      mosi_pipe <= '0;
    end else begin
      mosi_pipe[0] <= spi_mosi;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) mosi_pipe[i] <= mosi_pipe[i-1];
    end
  end
  assign mosi_sync = mosi_pipe[SYNC_STAGES-1];

  // A leading edge leaves SCLK away from its idle level.
  assign sclk_edge   = sclk_rise | sclk_fall;
  assign lead_edge   = sclk_edge & (sclk_sync ^ mode_q.cpol);
  assign trail_edge  = sclk_edge & ~(sclk_sync ^ mode_q.cpol);
  assign sample_edge = mode_q.cpha ? trail_edge : lead_edge;
  assign shift_edge  = mode_q.cpha ? lead_edge : trail_edge;

  assign len_in = (transfer_length > MAX_LEN) ? MAX_LEN : transfer_length;
  assign mask   = len_mask(len_q);

  always_comb begin
    for (int unsigned l = 0; l < N_CHANNELS; l++) begin
      rx_next[l]   = {rx_shift[l], mosi_sync[l]};
      rx_masked[l] = rx_next[l] & mask[OUTPUT_WIDTH-1:0];
      spi_miso[l]  = (state == SHIFT && drive) ? tx_shift[l][len_q] : 1'b0;
    end
  end

  assign tx_ready = (state == IDLE) && !ss_fall;

  always_ff @(posedge clock) begin
    if (!reset) state <= WAIT_SS_HIGH;
    else        state <= state_next;
  end

  always_comb begin
    state_next  = state;
    frame_start = 1'b0;
    sample_now  = 1'b0;
    shift_now   = 1'b0;
    finish_now  = 1'b0;
    abort_now   = 1'b0;
    tx_capture  = 1'b0;
    unique case (state)
      WAIT_SS_HIGH: if (ss_sync) state_next = IDLE;
      IDLE: begin
        if (ss_fall) begin
          frame_start = 1'b1;
          state_next  = SHIFT;
        end else begin
          tx_capture = tx_data_valid;
        end
      end
      SHIFT: begin
        shift_now = shift_edge;
        if (sample_edge) begin
          sample_now = 1'b1;
          if (bit_cnt == {1'b0, len_q}) begin
            finish_now = 1'b1;
            state_next = DONE;
          end
        end
        // A completing sample edge wins over a coincident SS_N release.
        if (ss_rise && !finish_now) begin
          abort_now  = 1'b1;
          state_next = IDLE;
        end
      end
      DONE: if (ss_sync) state_next = IDLE;
      default: state_next = WAIT_SS_HIGH;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      mode_q           <= '0;
      len_q            <= '0;
      bit_cnt          <= '0;
      drive            <= 1'b0;
      tx_have          <= 1'b0;
      tx_hold          <= '0;
      tx_shift         <= '0;
      rx_shift         <= '0;
      rx_data          <= '0;
      rx_valid         <= 1'b0;
      transfer_aborted <= 1'b0;
      tx_underrun      <= 1'b0;
    end else begin
      rx_valid         <= 1'b0;
      transfer_aborted <= 1'b0;
      tx_underrun      <= 1'b0;
      if (tx_capture) begin
        tx_hold <= tx_data;
        tx_have <= 1'b1;
      end
      if (frame_start) begin
        mode_q      <= '{cpol: clock_polarity, cpha: clock_phase};
        len_q       <= len_in;
        bit_cnt     <= '0;
        rx_shift    <= '0;
        drive       <= ~clock_phase;
        tx_have     <= 1'b0;
        tx_shift    <= tx_data_valid ? tx_data : (tx_have ? tx_hold : '0);
        tx_underrun <= ~tx_data_valid & ~tx_have;
      end
      if (sample_now) begin
        for (int unsigned l = 0; l < N_CHANNELS; l++) rx_shift[l] <= rx_next[l][OUTPUT_WIDTH-2:0];
        bit_cnt <= bit_cnt + 6'd1;
      end
      // With CPHA=1 the first shift edge only starts driving the already-loaded MSB.
      if (shift_now) begin
        if (drive) begin
          for (int unsigned l = 0; l < N_CHANNELS; l++) tx_shift[l] <= tx_shift[l] << 1;
        end else begin
          drive <= 1'b1;
        end
      end
      if (finish_now) begin
        rx_data  <= rx_masked;
        rx_valid <= 1'b1;
      end
      if (abort_now) transfer_aborted <= 1'b1;
    end
  end

endmodule
